// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Sends one command byte to the
// keyboard using the open-drain host-request sequence and reports whether
// the device acknowledged it. busy is also used outside this block to make
// the receive path ignore the bus while a command is in flight.
//
// Ports
//   CLOCK_50    in   system clock (50 MHz)
//   reset_n     in   asynchronous active-low reset
//   start       in   send request, only looked at in IDLE
//   cmd[7:0]    in   command byte, latched when start is accepted
//   busy        out  accepted start .. done pulse inclusive
//   done        out  one-cycle end-of-transfer pulse (success or abort)
//   ack_ok      out  device ACK seen; held until the next accepted start
//   error       out  timeout or missing ACK; held until the next accepted start
//   ps2_clk_in  in   PS2_CLK pad level
//   ps2_dat_in  in   PS2_DAT pad level
//   ps2_clk_oe  out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  out  1 = pull PS2_DAT low, 0 = release
//
// State       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for start
// S_INHIBIT   | clock held low; data pulled low on the last cycle (start bit)
// S_REQ       | clock released, data still low: request-to-send
// S_SEND      | shift D0..D7, parity, stop on device falling edges
// S_ACK       | sample device ACK on the 11th falling edge
// S_WAIT_IDLE | wait for both lines released high
// S_DONE      | one-cycle done pulse, busy drops afterwards
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int CLK_INHIBIT = 5000,
    parameter int TIMEOUT     = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = $clog2(CLK_INHIBIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t           r_state;
    logic [9:0]       r_frame;
    logic [3:0]       r_bitcnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_ok;
    logic             r_error;
    logic             r_clk_oe;
    logic             r_dat_oe;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_prev;
    logic             r_dat_s1;
    logic             r_dat_s2;

    logic             w_fall;
    logic             w_timed;
    logic             w_watched;

    // Two-flop synchronizers; r_clk_prev gives one more stage for edge detect.
    // Cleared to 0 so that reset can never manufacture a falling edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    always_comb begin
        w_fall    = r_clk_prev & ~r_clk_s2;
        w_watched = (r_state == S_SEND) || (r_state == S_ACK) ||
                    (r_state == S_WAIT_IDLE);
        // Timeout only fires when no bus event rescued the counter this cycle.
        w_timed   = w_watched && !w_fall && (r_tmo == '0);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_bitcnt  <= '0;
            r_inh_cnt <= '0;
            r_tmo     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Timeout down-counter: reloaded on every falling edge, else runs down.
            if (w_watched) begin
                if (w_fall) begin
                    r_tmo <= TMO_W'(TIMEOUT);
                end else if (r_tmo != '0) begin
                    r_tmo <= r_tmo - 1'b1;
                end
            end

            if (w_timed) begin
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_error  <= 1'b1;
                r_ack_ok <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_frame   <= {1'b1, ~^cmd, cmd};
                            r_busy    <= 1'b1;
                            r_ack_ok  <= 1'b0;
                            r_error   <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            // With a one-cycle inhibit the first cycle is also the last.
                            r_dat_oe  <= (CLK_INHIBIT == 1);
                            r_inh_cnt <= INH_W'(CLK_INHIBIT - 1);
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_inh_cnt == '0) begin
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b1;
                            r_state  <= S_REQ;
                        end else begin
                            r_inh_cnt <= r_inh_cnt - 1'b1;
                            if (r_inh_cnt == INH_W'(1)) begin
                                r_dat_oe <= 1'b1;
                            end
                        end
                    end
                    S_REQ: begin
                        r_bitcnt <= '0;
                        r_tmo    <= TMO_W'(TIMEOUT);
                        r_state  <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_fall) begin
                            r_dat_oe <= ~r_frame[r_bitcnt];
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_dat_s2) begin
                                r_ack_ok <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (r_clk_s2 && r_dat_s2) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ack_ok     = r_ack_ok;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule
